// File: rtl/aes_pkg.sv
// Shared AES definitions: controller states, key-length codes, round counts
// and the byte-level GF(2^8) helpers used by the round datapath.
package aes_pkg;

    localparam int STATE_W = 128;

    localparam logic [1:0] KEY_LEN_128 = 2'b00;
    localparam logic [1:0] KEY_LEN_192 = 2'b01;
    localparam logic [1:0] KEY_LEN_256 = 2'b10;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aesFsm_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Codes 10 and 11 both select AES-256.
    function automatic logic [3:0] nrFromKeyLen(input logic [1:0] keyLen);
        if ((keyLen & KEY_LEN_256) != 2'b00) return NR_256;
        if (keyLen == KEY_LEN_192) return NR_192;
        if (keyLen == KEY_LEN_128) return NR_128;
        return NR_256;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Purely combinational; state byte 0 sits in bits [127:120], bytes column-major.
module aes_round
    import aes_pkg::*;
(
    input  logic [STATE_W-1:0] stateIn,
    input  logic [STATE_W-1:0] roundKey,
    input  logic               lastRound,
    output logic [STATE_W-1:0] stateOut
);

    logic [7:0] subB   [16];
    logic [7:0] shiftB [16];
    logic [7:0] mixB   [16];

    for (genvar i = 0; i < 16; i++) begin : gSub
        assign subB[i] = sbox(stateIn[STATE_W-1-8*i -: 8]);
    end

    for (genvar c = 0; c < 4; c++) begin : gCol
        // Row r of the state rotates left by r columns.
        for (genvar r = 0; r < 4; r++) begin : gRow
            assign shiftB[4*c+r] = subB[4*((c+r)%4)+r];
        end
        assign mixB[4*c]   = xtime(shiftB[4*c]) ^ mul3(shiftB[4*c+1]) ^ shiftB[4*c+2] ^ shiftB[4*c+3];
        assign mixB[4*c+1] = shiftB[4*c] ^ xtime(shiftB[4*c+1]) ^ mul3(shiftB[4*c+2]) ^ shiftB[4*c+3];
        assign mixB[4*c+2] = shiftB[4*c] ^ shiftB[4*c+1] ^ xtime(shiftB[4*c+2]) ^ mul3(shiftB[4*c+3]);
        assign mixB[4*c+3] = mul3(shiftB[4*c]) ^ shiftB[4*c+1] ^ shiftB[4*c+2] ^ xtime(shiftB[4*c+3]);
    end

    for (genvar i = 0; i < 16; i++) begin : gAdd
        assign stateOut[STATE_W-1-8*i -: 8] = (lastRound ? shiftB[i] : mixB[i])
                                            ^ roundKey[STATE_W-1-8*i -: 8];
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES encryption round controller: iterates one shared round datapath Nr times
// per block, selecting each round key from the expanded-key bus by round index.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR_MAX = 14
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [1:0]                 key_len,
    input  logic [STATE_W-1:0]         plaintext,
    input  logic [32*4*(NR_MAX+1)-1:0] w,
    output logic                       busy,
    output logic [3:0]                 round,
    output logic                       out_valid,
    output logic [STATE_W-1:0]         ciphertext
);

    aesFsm_t            fsmQ, fsmD;
    logic [3:0]         nrQ, nrD;
    logic [3:0]         roundD;
    logic [STATE_W-1:0] aesStateQ, aesStateD;
    logic [STATE_W-1:0] cipherD;
    logic [STATE_W-1:0] rkTable [NR_MAX+1];
    logic [STATE_W-1:0] roundKey;
    logic [STATE_W-1:0] roundOut;
    logic               lastRound;

    // Word 4r lands in the most significant word of round key r.
    for (genvar r = 0; r <= NR_MAX; r++) begin : gKey
        assign rkTable[r] = {w[128*r +: 32], w[128*r+32 +: 32],
                             w[128*r+64 +: 32], w[128*r+96 +: 32]};
    end

    // round is 0 in IDLE, so the same mux supplies the initial whitening key.
    assign roundKey  = (round <= 4'(NR_MAX)) ? rkTable[round] : '0;
    assign lastRound = (round == nrQ);

    aes_round uRound (
        .stateIn  (aesStateQ),
        .roundKey (roundKey),
        .lastRound(lastRound),
        .stateOut (roundOut)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fsmQ       <= ST_IDLE;
            nrQ        <= '0;
            round      <= '0;
            aesStateQ  <= '0;
            ciphertext <= '0;
        end else begin
            fsmQ       <= fsmD;
            nrQ        <= nrD;
            round      <= roundD;
            aesStateQ  <= aesStateD;
            ciphertext <= cipherD;
        end
    end

    always_comb begin
        fsmD      = fsmQ;
        nrD       = nrQ;
        roundD    = round;
        aesStateD = aesStateQ;
        cipherD   = ciphertext;
        case (fsmQ)
            ST_IDLE: begin
                if (start) begin
                    fsmD      = ST_RUN;
                    nrD       = nrFromKeyLen(key_len);
                    roundD    = 4'd1;
                    aesStateD = plaintext ^ roundKey;
                end
            end
            ST_RUN: begin
                aesStateD = roundOut;
                if (lastRound) begin
                    cipherD = roundOut;
                    fsmD    = ST_DONE;
                end else begin
                    roundD = round + 4'd1;
                end
            end
            ST_DONE: begin
                fsmD   = ST_IDLE;
                roundD = '0;
            end
            default: begin
                fsmD   = ST_IDLE;
                roundD = '0;
            end
        endcase
    end

    assign busy      = (fsmQ == ST_RUN);
    assign out_valid = (fsmQ == ST_DONE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: FIPS-197 vectors, ignored starts, mid-block
// reset, back-to-back blocks and key_len changes, checked through a scoreboard.
module tb_aes_round_ctrl;

    logic           clk;
    logic           reset;
    logic           start;
    logic [1:0]     keyLen;
    logic [127:0]   plaintext;
    logic [1919:0]  wBus;
    logic           busy;
    logic [3:0]     round;
    logic           out_valid;
    logic [127:0]   ciphertext;

    aes_round_ctrl #(.NR_MAX(14)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key_len   (keyLen),
        .plaintext (plaintext),
        .w         (wBus),
        .busy      (busy),
        .round     (round),
        .out_valid (out_valid),
        .ciphertext(ciphertext)
    );

    typedef struct {
        logic [127:0] ct;
        int           cyc;
    } exp_t;

    exp_t       sbq[$];
    exp_t       monEntry;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pulses = 0;
    int         curNr = 0;
    logic [7:0] tbSbox [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model pieces (key schedule only) ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from the multiplicative inverse plus affine map.
    task automatic initSbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            tbSbox[8'(a)] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subWord(input logic [31:0] t);
        return {tbSbox[t[31:24]], tbSbox[t[23:16]], tbSbox[t[15:8]], tbSbox[t[7:0]]};
    endfunction

    function automatic int nrOf(input logic [1:0] kl);
        if (kl == 2'b00) return 10;
        if (kl == 2'b01) return 12;
        return 14;
    endfunction

    // Unused upper words are random so a round key indexed too high is visible.
    function automatic logic [1919:0] expandKey(input logic [255:0] key, input int nk);
        logic [59:0][31:0] wd;
        logic [255:0]      kk;
        logic [31:0]       t;
        logic [7:0]        rc;
        int                total;
        total = 4 * (nk + 7);
        kk = key;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) wd[6'(i)] = $urandom();
        for (int i = 0; i < total; i++) begin
            if (i < nk) begin
                wd[6'(i)] = kk[255:224];
                kk = kk << 32;
            end else begin
                t = wd[6'(i-1)];
                if (i % nk == 0) begin
                    t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subWord(t);
                end
                wd[6'(i)] = wd[6'(i-nk)] ^ t;
            end
        end
        return wd;
    endfunction

    function automatic logic [255:0] vecKey(input int v);
        case (v)
            0:       return {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
            1:       return {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
            2:       return 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
            default: return {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        endcase
    endfunction

    function automatic logic [127:0] vecPt(input int v);
        if (v == 3) return 128'h3243f6a8885a308d313198a2e0370734;
        return 128'h00112233445566778899aabbccddeeff;
    endfunction

    function automatic logic [127:0] vecCt(input int v);
        case (v)
            0:       return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
            1:       return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
            2:       return 128'h8ea2b7ca516745bfeafc49904b496089;
            default: return 128'h3925841d02dc09fbdc118597196a0b32;
        endcase
    endfunction

    task automatic loadVector(input int v, input logic [1:0] kl);
        keyLen    = kl;
        plaintext = vecPt(v);
        wBus      = expandKey(vecKey(v), nrOf(kl) - 6);
    endtask

    task automatic pushExpect(input int v, input logic [1:0] kl, input int startCyc);
        exp_t e;
        e.ct  = vecCt(v);
        e.cyc = startCyc + nrOf(kl) + 1;
        sbq.push_back(e);
        curNr = nrOf(kl);
    endtask

    // Start sampled at the posedge after this negedge; returns in round 1.
    task automatic startBlock(input int v, input logic [1:0] kl);
        @(negedge clk);
        loadVector(v, kl);
        start = 1'b1;
        pushExpect(v, kl, cyc);
        @(negedge clk);
        start = 1'b0;
        check("busy after start", 128'(busy), 128'(1));
        check("round after start", 128'(round), 128'(1));
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, " drained"}, 128'(sbq.size()), 128'(0));
    endtask

    task automatic checkIdle(input string tag, input logic [127:0] ct);
        @(negedge clk);
        check({tag, " busy idle"}, 128'(busy), 128'(0));
        check({tag, " round idle"}, 128'(round), 128'(0));
        check({tag, " ct held"}, ciphertext, ct);
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (busy) check("round within Nr", 128'(round <= curNr), 128'(1));
        if (out_valid) begin
            pulses++;
            check("out_valid expected", 128'(sbq.size() != 0), 128'(1));
            if (sbq.size() != 0) begin
                monEntry = sbq.pop_front();
                check("ciphertext", ciphertext, monEntry.ct);
                check("latency cycle", 128'(cyc), 128'(monEntry.cyc));
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int p0;
        reset     = 1'b1;
        start     = 1'b1;
        keyLen    = 2'b00;
        plaintext = '0;
        wBus      = '0;
        initSbox();

        // Reset with start held high: reset wins.
        repeat (3) @(negedge clk);
        check("reset busy", 128'(busy), 128'(0));
        check("reset out_valid", 128'(out_valid), 128'(0));
        check("reset round", 128'(round), 128'(0));
        check("reset ciphertext", ciphertext, 128'(0));
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Standard vectors for each key length.
        startBlock(0, 2'b00);
        waitDrain("aes128", 40);
        checkIdle("aes128", vecCt(0));
        startBlock(1, 2'b01);
        waitDrain("aes192", 40);
        checkIdle("aes192", vecCt(1));
        startBlock(2, 2'b10);
        waitDrain("aes256", 40);
        checkIdle("aes256", vecCt(2));

        // key_len=11 behaves as AES-256; changes mid-block are ignored.
        startBlock(2, 2'b11);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            keyLen = 2'(k);
        end
        waitDrain("keylen11 toggled", 40);
        checkIdle("keylen11 toggled", vecCt(2));

        // Second start at round 5 is ignored.
        p0 = pulses;
        startBlock(3, 2'b00);
        repeat (4) @(negedge clk);
        check("round before restart", 128'(round), 128'(5));
        start     = 1'b1;
        plaintext = ~plaintext;
        @(negedge clk);
        start = 1'b0;
        check("busy after ignored start", 128'(busy), 128'(1));
        check("round after ignored start", 128'(round), 128'(6));
        waitDrain("ignored start", 40);
        repeat (15) @(negedge clk);
        check("single pulse", 128'(pulses - p0), 128'(1));

        // Reset at round 7 of AES-256 aborts silently.
        startBlock(2, 2'b10);
        repeat (6) @(negedge clk);
        check("round before abort", 128'(round), 128'(7));
        reset = 1'b1;
        sbq.delete();
        p0 = pulses;
        @(negedge clk);
        check("abort busy", 128'(busy), 128'(0));
        check("abort out_valid", 128'(out_valid), 128'(0));
        check("abort round", 128'(round), 128'(0));
        check("abort ciphertext", ciphertext, 128'(0));
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("no pulse after abort", 128'(pulses - p0), 128'(0));
        startBlock(2, 2'b10);
        waitDrain("after abort", 40);
        checkIdle("after abort", vecCt(2));

        // start held for three back-to-back AES-128 blocks.
        p0 = pulses;
        @(negedge clk);
        loadVector(0, 2'b00);
        start = 1'b1;
        pushExpect(0, 2'b00, cyc);
        for (int b = 1; b < 3; b++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 30);
            loadVector((b == 1) ? 3 : 0, 2'b00);
            pushExpect((b == 1) ? 3 : 0, 2'b00, cyc + 1);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 30);
        start = 1'b0;
        #1;
        waitDrain("back-to-back", 40);
        checkIdle("back-to-back", vecCt(0));
        check("back-to-back pulses", 128'(pulses - p0), 128'(3));

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
